// File: rtl/plic_lite.sv
// plic_lite: platform-level interrupt controller for a single hart.
// Level-sensitive sources pass through a pending/in_service gateway. Each
// source has a priority and an enable, and there is one global threshold.
// The best eligible source drives a registered notify line. Software claims
// the best source by reading the claim register and hands it back by writing
// its ID to the same register.
module plic_lite #(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   irq_src,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [7:0]        req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              PLIC_notif
);

  localparam int ID_W = 5;

  // Word indices (byte address / 4). Priority words occupy 0..NSRC-1.
  localparam logic [5:0] W_PEND  = 6'h20;
  localparam logic [5:0] W_EN    = 6'h21;
  localparam logic [5:0] W_THR   = 6'h22;
  localparam logic [5:0] W_CLAIM = 6'h23;

  logic [PRIO_W-1:0] prio [NSRC];
  logic [NSRC-1:0]   enable;
  logic [PRIO_W-1:0] threshold;
  logic [NSRC-1:0]   pending;
  logic [NSRC-1:0]   in_service;

  logic [NSRC-1:0]   pending_next;
  logic [NSRC-1:0]   in_service_next;
  logic [ID_W-1:0]   best_id;
  logic [PRIO_W-1:0] best_prio;
  logic [31:0]       rdata_next;

  logic [5:0] req_word;
  logic       wr_en;
  logic       rd_en;
  logic       claim;
  logic       complete;
  logic       unused_bits;

  assign req_word = req_addr[7:2];
  assign wr_en    = req_valid & req_we;
  assign rd_en    = req_valid & ~req_we;
  assign claim    = rd_en & (req_word == W_CLAIM);
  assign complete = wr_en & (req_word == W_CLAIM);

  // Byte-lane bits of the address and high write-data bits carry no meaning.
  assign unused_bits = ^{req_addr[1:0], req_wdata};

  // Arbitration: strictly-greater compare in ascending ID order, so ties
  // resolve to the lowest ID. Eligible sources always have priority >= 1.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (pending[i] && enable[i] && (prio[i] > threshold) && (prio[i] > best_prio)) begin
        best_id   = ID_W'(i + 1);
        best_prio = prio[i];
      end
    end
  end

  // Read data mux, sampled into resp_rdata on the request edge.
  always_comb begin
    rdata_next = '0;
    case (req_word)
      W_PEND:  rdata_next[NSRC-1:0]   = pending;
      W_EN:    rdata_next[NSRC-1:0]   = enable;
      W_THR:   rdata_next[PRIO_W-1:0] = threshold;
      W_CLAIM: rdata_next[ID_W-1:0]   = best_id;
      default: begin
        for (int i = 0; i < NSRC; i++) begin
          if (req_word == 6'(i)) begin
            rdata_next[PRIO_W-1:0] = prio[i];
          end
        end
      end
    endcase
  end

  // Gateway next state: a claim takes the source out of pending and into
  // service; in_service blocks re-pending until the matching complete.
  always_comb begin
    pending_next    = pending;
    in_service_next = in_service;
    for (int i = 0; i < NSRC; i++) begin
      if (claim && (best_id == ID_W'(i + 1))) begin
        pending_next[i]    = 1'b0;
        in_service_next[i] = 1'b1;
      end else if (irq_src[i] && !pending[i] && !in_service[i]) begin
        pending_next[i] = 1'b1;
      end
      if (complete && (req_wdata[ID_W-1:0] == ID_W'(i + 1)) && in_service[i]) begin
        in_service_next[i] = 1'b0;
      end
    end
  end

  // Software-visible configuration registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSRC; i++) begin
        prio[i] <= '0;
      end
      enable    <= '0;
      threshold <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NSRC; i++) begin
        if (req_word == 6'(i)) begin
          prio[i] <= req_wdata[PRIO_W-1:0];
        end
      end
      if (req_word == W_EN) begin
        enable <= req_wdata[NSRC-1:0];
      end
      if (req_word == W_THR) begin
        threshold <= req_wdata[PRIO_W-1:0];
      end
    end
  end

  // Gateway state and the registered notify line.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      in_service <= '0;
      PLIC_notif <= 1'b0;
    end else begin
      pending    <= pending_next;
      in_service <= in_service_next;
      PLIC_notif <= (best_id != '0);
    end
  end

  // One-cycle response for every request; writes return zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= req_valid;
      resp_rdata <= rd_en ? rdata_next : '0;
    end
  end

endmodule
